// File: rtl/pit_fib_responder.sv
// Pending-interest table: merges/drops/forwards interests to the FIB and answers data-arrival queries, then captures the payload stream.
// Lookup request and query response one cycle after the sampled input; payload one cycle behind out_data; interest_ready low while a lookup is outstanding.
module pit_fib_responder #(
   parameter int ENTRIES    = 8,
   parameter int DATA_BYTES = 1024,
   parameter int IDX_W      = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        interest_valid,
   input  logic [63:0] interest_prefix,
   input  logic [5:0]  interest_len,
   output logic        interest_ready,
   output logic        interest_dup,
   output logic        interest_drop,
   output logic        fib_out_bit,
   output logic [63:0] pit_in_prefix,
   output logic [5:0]  pit_in_len,
   input  logic        fib_lookup_done,
   input  logic [63:0] longest_matching_prefix,
   input  logic [5:0]  longest_matching_prefix_len,
   output logic        route_valid,
   output logic [63:0] route_prefix,
   output logic [5:0]  route_len,
   input  logic        prefix_ready,
   input  logic [63:0] pit_out_prefix,
   input  logic [5:0]  pit_out_len,
   output logic        start_send_to_pit,
   output logic        rejected,
   input  logic [7:0]  out_data,
   output logic [7:0]  data_out,
   output logic        data_out_valid,
   output logic        data_last,
   output logic        stream_busy
);

   localparam int CNT_W = ($clog2(DATA_BYTES) > 10) ? $clog2(DATA_BYTES) : 10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BYTES - 1);

   typedef struct packed {
      logic [63:0] prefix;
      logic [5:0]  len;
   } name_t;

   typedef enum logic {I_IDLE, I_WAIT} istate_t;
   typedef enum logic [1:0] {D_IDLE, D_RESP, D_STREAM} dstate_t;

   istate_t istate;
   dstate_t dstate;

   logic [ENTRIES-1:0] tbl_vld;
   name_t              tbl_dat [ENTRIES];

   name_t            ins_name;
   name_t            dat_name;
   logic             ins_hit;
   logic             dat_hit;
   logic [IDX_W-1:0] dat_idx;
   logic             free_vld;
   logic [IDX_W-1:0] free_idx;
   logic             ins_fire;
   logic             do_insert;
   logic             do_clear;
   logic             resp_hit;
   logic [IDX_W-1:0] resp_idx;
   logic [CNT_W-1:0] byte_cnt;

   assign ins_name = {interest_prefix, interest_len};
   assign dat_name = {pit_out_prefix, pit_out_len};

   // Descending scan so the lowest matching / free index is the one left standing.
   always_comb begin
      ins_hit  = 1'b0;
      dat_hit  = 1'b0;
      dat_idx  = '0;
      free_vld = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (tbl_vld[i] && (tbl_dat[i] == ins_name)) ins_hit = 1'b1;
         if (tbl_vld[i] && (tbl_dat[i] == dat_name)) begin
            dat_hit = 1'b1;
            dat_idx = IDX_W'(i);
         end
         if (!tbl_vld[i]) begin
            free_vld = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   assign ins_fire  = interest_ready & interest_valid;
   assign do_insert = ins_fire & ~ins_hit & free_vld;
   assign do_clear  = (dstate == D_RESP) & resp_hit;

   // Insert only targets a slot that was already free, so it never collides with the clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tbl_vld <= '0;
         for (int i = 0; i < ENTRIES; i++) tbl_dat[i] <= '0;
      end else begin
         if (do_clear) tbl_vld[resp_idx] <= 1'b0;
         if (do_insert) begin
            tbl_vld[free_idx] <= 1'b1;
            tbl_dat[free_idx] <= ins_name;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         istate         <= I_IDLE;
         interest_ready <= 1'b0;
         interest_dup   <= 1'b0;
         interest_drop  <= 1'b0;
         fib_out_bit    <= 1'b0;
         pit_in_prefix  <= '0;
         pit_in_len     <= '0;
         route_valid    <= 1'b0;
         route_prefix   <= '0;
         route_len      <= '0;
      end else begin
         interest_dup  <= 1'b0;
         interest_drop <= 1'b0;
         fib_out_bit   <= 1'b0;
         route_valid   <= 1'b0;
         if (istate == I_IDLE) begin
            interest_ready <= 1'b1;
            if (ins_fire) begin
               if (ins_hit) begin
                  interest_dup <= 1'b1;
               end else if (free_vld) begin
                  fib_out_bit    <= 1'b1;
                  pit_in_prefix  <= interest_prefix;
                  pit_in_len     <= interest_len;
                  interest_ready <= 1'b0;
                  istate         <= I_WAIT;
               end else begin
                  interest_drop <= 1'b1;
               end
            end
         end else if (fib_lookup_done) begin
            route_prefix   <= longest_matching_prefix;
            route_len      <= longest_matching_prefix_len;
            route_valid    <= 1'b1;
            interest_ready <= 1'b1;
            istate         <= I_IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dstate            <= D_IDLE;
         resp_hit          <= 1'b0;
         resp_idx          <= '0;
         start_send_to_pit <= 1'b0;
         rejected          <= 1'b0;
         stream_busy       <= 1'b0;
         byte_cnt          <= '0;
         data_out          <= '0;
         data_out_valid    <= 1'b0;
         data_last         <= 1'b0;
      end else begin
         start_send_to_pit <= 1'b0;
         rejected          <= 1'b0;
         data_out_valid    <= 1'b0;
         data_last         <= 1'b0;
         case (dstate)
            D_IDLE: begin
               if (prefix_ready) begin
                  resp_hit          <= dat_hit;
                  resp_idx          <= dat_idx;
                  start_send_to_pit <= dat_hit;
                  rejected          <= ~dat_hit;
                  stream_busy       <= dat_hit;
                  dstate            <= D_RESP;
               end
            end
            D_RESP: begin
               byte_cnt <= '0;
               dstate   <= resp_hit ? D_STREAM : D_IDLE;
            end
            D_STREAM: begin
               data_out       <= out_data;
               data_out_valid <= 1'b1;
               data_last      <= (byte_cnt == CNT_LAST);
               if (byte_cnt == CNT_LAST) begin
                  stream_busy <= 1'b0;
                  dstate      <= D_IDLE;
               end else begin
                  byte_cnt <= byte_cnt + 1'b1;
               end
            end
            default: dstate <= D_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pit_fib_responder.sv
// Randomized bench for pit_fib_responder against a pending-name queue model.
module tb_pit_fib_responder;

   localparam int ENTRIES = 8;
   localparam int DB      = 1024;

   typedef struct packed {
      logic [63:0] p;
      logic [5:0]  l;
   } name_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        interest_valid = 1'b0;
   logic [63:0] interest_prefix = '0;
   logic [5:0]  interest_len = '0;
   logic        interest_ready, interest_dup, interest_drop, fib_out_bit;
   logic [63:0] pit_in_prefix;
   logic [5:0]  pit_in_len;
   logic        fib_lookup_done = 1'b0;
   logic [63:0] longest_matching_prefix = '0;
   logic [5:0]  longest_matching_prefix_len = '0;
   logic        route_valid;
   logic [63:0] route_prefix;
   logic [5:0]  route_len;
   logic        prefix_ready = 1'b0;
   logic [63:0] pit_out_prefix = '0;
   logic [5:0]  pit_out_len = '0;
   logic        start_send_to_pit, rejected;
   logic [7:0]  out_data = '0;
   logic [7:0]  data_out;
   logic        data_out_valid, data_last, stream_busy;

   int errs = 0;
   int checks = 0;
   name_t pend[$];

   logic [157:0] all_out;
   assign all_out = {interest_ready, interest_dup, interest_drop, fib_out_bit,
                     pit_in_prefix, pit_in_len, route_valid, route_prefix, route_len,
                     start_send_to_pit, rejected, data_out, data_out_valid, data_last,
                     stream_busy};

   pit_fib_responder #(.ENTRIES(ENTRIES), .DATA_BYTES(DB), .IDX_W(3)) dut (
      .clk(clk), .rst(rst),
      .interest_valid(interest_valid), .interest_prefix(interest_prefix),
      .interest_len(interest_len), .interest_ready(interest_ready),
      .interest_dup(interest_dup), .interest_drop(interest_drop),
      .fib_out_bit(fib_out_bit), .pit_in_prefix(pit_in_prefix), .pit_in_len(pit_in_len),
      .fib_lookup_done(fib_lookup_done), .longest_matching_prefix(longest_matching_prefix),
      .longest_matching_prefix_len(longest_matching_prefix_len),
      .route_valid(route_valid), .route_prefix(route_prefix), .route_len(route_len),
      .prefix_ready(prefix_ready), .pit_out_prefix(pit_out_prefix), .pit_out_len(pit_out_len),
      .start_send_to_pit(start_send_to_pit), .rejected(rejected),
      .out_data(out_data), .data_out(data_out), .data_out_valid(data_out_valid),
      .data_last(data_last), .stream_busy(stream_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int find(name_t n);
      for (int i = 0; i < pend.size(); i++) if (pend[i] == n) return i;
      return -1;
   endfunction

   function automatic name_t rand_name();
      name_t n;
      n.p = {$urandom(), $urandom()};
      n.l = 6'($urandom_range(0, 63));
      return n;
   endfunction

   task automatic do_interest(input logic [63:0] p, input logic [5:0] l, input logic [5:0] rl);
      name_t n;
      int idx;
      bit e_dup, e_fib, e_drop;
      logic [63:0] rp;
      n = {p, l};
      idx = find(n);
      e_dup  = (idx >= 0);
      e_fib  = !e_dup && (pend.size() < ENTRIES);
      e_drop = !e_dup && !e_fib;
      checks++;
      if (interest_ready !== 1'b1) begin
         errs++; $display("FAIL interest_ready idle: got %b exp 1", interest_ready);
      end
      interest_valid = 1'b1; interest_prefix = p; interest_len = l;
      tick();
      interest_valid = 1'b0;
      checks++;
      if ({interest_dup, interest_drop, fib_out_bit} !== {e_dup, e_drop, e_fib}) begin
         errs++;
         $display("FAIL interest outcome: got dup/drop/fib=%b%b%b exp %b%b%b",
                  interest_dup, interest_drop, fib_out_bit, e_dup, e_drop, e_fib);
      end
      if (e_fib) begin
         pend.push_back(n);
         checks++;
         if ({pit_in_prefix, pit_in_len, interest_ready} !== {p, l, 1'b0}) begin
            errs++; $display("FAIL lookup echo: got %h/%0d rdy=%b exp %h/%0d rdy=0",
                             pit_in_prefix, pit_in_len, interest_ready, p, l);
         end
         repeat ($urandom_range(1, 3)) begin
            tick();
            checks++;
            if ({fib_out_bit, route_valid, interest_ready, pit_in_prefix, pit_in_len} !== {3'b000, p, l}) begin
               errs++; $display("FAIL lookup wait: got fib=%b rv=%b rdy=%b pit_in=%h/%0d",
                                fib_out_bit, route_valid, interest_ready, pit_in_prefix, pit_in_len);
            end
         end
         rp = {$urandom(), $urandom()};
         fib_lookup_done = 1'b1; longest_matching_prefix = rp; longest_matching_prefix_len = rl;
         tick();
         fib_lookup_done = 1'b0;
         checks++;
         if ({route_valid, route_prefix, route_len} !== {1'b1, rp, rl}) begin
            errs++; $display("FAIL route result: got v=%b %h/%0d exp 1 %h/%0d",
                             route_valid, route_prefix, route_len, rp, rl);
         end
         tick();
         checks++;
         if ({route_valid, interest_ready, route_prefix, route_len} !== {2'b01, rp, rl}) begin
            errs++; $display("FAIL route pulse end: got v=%b rdy=%b len=%0d exp v=0 rdy=1 len=%0d",
                             route_valid, interest_ready, route_len, rl);
         end
      end else begin
         tick();
         checks++;
         if ({interest_dup, interest_drop, fib_out_bit} !== 3'b000) begin
            errs++; $display("FAIL interest pulse end: got %b%b%b exp 000",
                             interest_dup, interest_drop, fib_out_bit);
         end
      end
   endtask

   // Leaves the bench in the cycle after the sampling edge; caller drives the next edge.
   task automatic query_resp(input name_t n, output int idx);
      prefix_ready = 1'b1; pit_out_prefix = n.p; pit_out_len = n.l;
      idx = find(n);
      tick();
      prefix_ready = 1'b0;
      checks++;
      if ({start_send_to_pit, rejected, stream_busy} !== {idx >= 0, idx < 0, idx >= 0}) begin
         errs++; $display("FAIL query response: got st/rj/busy=%b%b%b exp hit=%0d",
                          start_send_to_pit, rejected, stream_busy, idx >= 0);
      end
   endtask

   task automatic finish_resp(input bit hit);
      tick();
      checks++;
      if ({start_send_to_pit, rejected, stream_busy} !== {2'b00, hit}) begin
         errs++; $display("FAIL response pulse end: got st/rj/busy=%b%b%b exp 00%b",
                          start_send_to_pit, rejected, stream_busy, hit);
      end
   endtask

   task automatic run_stream(input bit rnd, input int abort_at, input bit hold);
      logic [7:0] b;
      for (int k = 0; k < DB; k++) begin
         b = rnd ? 8'($urandom()) : k[7:0];
         out_data = b;
         prefix_ready = hold;
         if (k == abort_at) begin
            rst = 1'b0;
            #1;
            checks++;
            if (all_out !== '0) begin
               errs++; $display("FAIL reset mid-stream: outputs %h not all zero", all_out);
            end
            pend.delete();
            prefix_ready = 1'b0; out_data = '0;
            tick();
            rst = 1'b1;
            tick(); tick();
            return;
         end
         tick();
         checks++;
         if ({data_out_valid, data_out, data_last, stream_busy, start_send_to_pit, rejected}
             !== {1'b1, b, k == DB - 1, k != DB - 1, 2'b00}) begin
            errs++;
            $display("FAIL stream byte %0d: got v=%b d=%h last=%b busy=%b st/rj=%b%b exp d=%h last=%b",
                     k, data_out_valid, data_out, data_last, stream_busy,
                     start_send_to_pit, rejected, b, k == DB - 1);
         end
      end
      prefix_ready = 1'b0;
      tick();
      checks++;
      if ({data_out_valid, data_last, stream_busy, start_send_to_pit, rejected} !== 5'b0) begin
         errs++; $display("FAIL stream end: got v=%b last=%b busy=%b st/rj=%b%b",
                          data_out_valid, data_last, stream_busy, start_send_to_pit, rejected);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) tick();
      checks++;
      if (all_out !== '0) begin
         errs++; $display("FAIL reset outputs: got %h exp 0", all_out);
      end
      rst = 1'b1;
      repeat (2) tick();
      checks++;
      if (interest_ready !== 1'b1) begin
         errs++; $display("FAIL ready after reset: got %b exp 1", interest_ready);
      end
   endtask

   task automatic test_insert_route();
      do_interest(64'hA5A5_0000_0000_0001, 6'd16, 6'd8);
   endtask

   task automatic test_dup();
      do_interest(64'hA5A5_0000_0000_0001, 6'd16, 6'd0);
      do_interest(64'hA5A5_0000_0000_0001, 6'd17, 6'($urandom_range(0, 63)));
   endtask

   task automatic test_data_stream();
      int idx;
      name_t n;
      n = {64'hA5A5_0000_0000_0001, 6'd16};
      query_resp(n, idx);
      finish_resp(idx >= 0);
      if (idx >= 0) begin
         pend.delete(idx);
         run_stream(1'b0, -1, 1'b0);
      end
      query_resp(n, idx);
      finish_resp(idx >= 0);
   endtask

   task automatic test_unknown();
      int idx;
      query_resp(rand_name(), idx);
      finish_resp(idx >= 0);
   endtask

   task automatic fill_table();
      name_t n;
      while (pend.size() < ENTRIES) begin
         n = rand_name();
         if (find(n) < 0) do_interest(n.p, n.l, 6'($urandom_range(0, 63)));
      end
   endtask

   task automatic test_fill();
      int idx;
      name_t n;
      fill_table();
      do_interest({$urandom(), $urandom()}, 6'($urandom_range(0, 63)), 6'd0);
      query_resp(pend[3], idx);
      finish_resp(idx >= 0);
      if (idx >= 0) begin
         pend.delete(idx);
         run_stream(1'b1, -1, 1'b0);
      end
      n = rand_name();
      do_interest(n.p, n.l, 6'd5);
      n = rand_name();
      do_interest(n.p, n.l, 6'd5);
   endtask

   task automatic test_hold_ignored();
      int idx;
      name_t other;
      query_resp(pend[0], idx);
      finish_resp(idx >= 0);
      if (idx >= 0) pend.delete(idx);
      other = pend[0];
      pit_out_prefix = other.p; pit_out_len = other.l;
      if (idx >= 0) run_stream(1'b1, -1, 1'b1);
      query_resp(other, idx);
      finish_resp(idx >= 0);
      if (idx >= 0) begin
         pend.delete(idx);
         run_stream(1'b1, -1, 1'b0);
      end
   endtask

   task automatic test_simultaneous();
      int idx;
      name_t p, q;
      bit e_dup, e_drop, e_fib;
      fill_table();
      // Table full: a new name arriving on the clear edge cannot take the freed slot.
      p = pend[0];
      q = rand_name();
      query_resp(p, idx);
      e_drop = (pend.size() >= ENTRIES) && (find(q) < 0);
      interest_valid = 1'b1; interest_prefix = q.p; interest_len = q.l;
      tick();
      interest_valid = 1'b0;
      checks++;
      if ({interest_drop, interest_dup, fib_out_bit, start_send_to_pit, rejected} !== {e_drop, 4'b0000}) begin
         errs++; $display("FAIL insert on clear edge (full): got drop/dup/fib=%b%b%b st/rj=%b%b exp drop=%b",
                          interest_drop, interest_dup, fib_out_bit, start_send_to_pit, rejected, e_drop);
      end
      if (idx >= 0) pend.delete(idx);
      run_stream(1'b1, -1, 1'b0);
      // Same name inserted on its own clear edge is merged, then gone.
      p = pend[0];
      query_resp(p, idx);
      e_dup = (find(p) >= 0);
      interest_valid = 1'b1; interest_prefix = p.p; interest_len = p.l;
      tick();
      interest_valid = 1'b0;
      checks++;
      if ({interest_dup, interest_drop, fib_out_bit} !== {e_dup, 2'b00}) begin
         errs++; $display("FAIL insert on clear edge (same): got dup/drop/fib=%b%b%b exp dup=%b",
                          interest_dup, interest_drop, fib_out_bit, e_dup);
      end
      if (idx >= 0) pend.delete(idx);
      run_stream(1'b0, -1, 1'b0);
      query_resp(p, idx);
      finish_resp(idx >= 0);
      query_resp(q, idx);
      finish_resp(idx >= 0);
      e_fib = (pend.size() < ENTRIES);
      checks++;
      if (e_fib !== 1'b1) begin
         errs++; $display("FAIL model occupancy: got %0d entries exp < %0d", pend.size(), ENTRIES);
      end
      do_interest(q.p, q.l, 6'd3);
   endtask

   task automatic test_reset_mid_stream();
      int idx;
      name_t saved[$];
      saved = pend;
      query_resp(pend[0], idx);
      finish_resp(idx >= 0);
      if (idx >= 0) run_stream(1'b0, 500, 1'b0);
      foreach (saved[i]) begin
         query_resp(saved[i], idx);
         finish_resp(idx >= 0);
      end
      do_interest(saved[0].p, saved[0].l, 6'd1);
   endtask

   initial begin
      test_reset();
      test_insert_route();
      test_dup();
      test_data_stream();
      test_unknown();
      test_fill();
      test_hold_ignored();
      test_simultaneous();
      test_reset_mid_stream();
      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
